// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel window generator.
// Window slice k = 3*row + col, row 0 = oldest line, col 0 = leftmost.
package sobel_pkg;
    localparam int DATA_W         = 8;
    localparam int IMG_WIDTH_DEF  = 1280;
    localparam int IMG_HEIGHT_DEF = 720;

    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;
endpackage

// File: rtl/sobel_line_buf.sv
// One image-line memory: asynchronous read, synchronous write, shared address.
module sobel_line_buf #(
    parameter int DEPTH  = 1280,
    parameter int DATA_W = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    import sobel_pkg::*;

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream in, 3x3 neighbourhood per interior pixel out, one-deep output register.
// Optional SOBEL_WIN_FRAME_CNT_EN adds a 16-bit count of completed frames (Frame_cnt).
module sobel_window_gen #(
    parameter int IMG_WIDTH  = sobel_pkg::IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = sobel_pkg::IMG_HEIGHT_DEF,
    parameter int DATA_W     = sobel_pkg::DATA_W
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Valid_in,
    input  logic [DATA_W-1:0]   Data_in,
    output logic                Ready_from_IP,
    output logic                Win_valid,
    output logic [9*DATA_W-1:0] Win_data,
    input  logic                Win_ready,
    output logic                Win_last
`ifdef SOBEL_WIN_FRAME_CNT_EN
    ,
    output logic [15:0]         Frame_cnt
`endif
);
    import sobel_pkg::*;

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    state_t            state;
    logic              accept, col_end, frame_end, emit;
    logic [DATA_W-1:0] lb0_q, lb1_q;
    logic [DATA_W-1:0] win [9];

    assign Ready_from_IP = !Win_valid || Win_ready;
    assign accept        = Valid_in && Ready_from_IP;
    assign col_end       = (col == COL_LAST);
    assign frame_end     = col_end && (row == ROW_LAST);
    assign emit          = accept && (state == STREAM) && (col >= CW'(2));

    // lb0 takes lb1's old value at the same address, so the two lines age together
    sobel_line_buf #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb0 (
        .clk(Clk), .we(accept), .addr(col), .wdata(lb1_q), .rdata(lb0_q)
    );
    sobel_line_buf #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb1 (
        .clk(Clk), .we(accept), .addr(col), .wdata(Data_in), .rdata(lb1_q)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            col   <= '0;
            row   <= '0;
            state <= FILL;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= frame_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
            case (state)
                FILL:    if (row == RW'(1) && col_end) state <= STREAM;
                STREAM:  if (frame_end) state <= FILL;
                default: state <= FILL;
            endcase
        end
    end

    // Shift regs only move on accept, so they double as the held output data
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int k = 0; k < 9; k++) win[k] <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[3*r]     <= win[3*r + 1];
                win[3*r + 1] <= win[3*r + 2];
            end
            win[WIN_TR] <= lb0_q;
            win[WIN_MR] <= lb1_q;
            win[WIN_BR] <= Data_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Win_valid <= 1'b0;
            Win_last  <= 1'b0;
        end else if (emit) begin
            Win_valid <= 1'b1;
            Win_last  <= frame_end;
        end else if (Win_ready) begin
            Win_valid <= 1'b0;
            Win_last  <= 1'b0;
        end
    end

    always_comb begin
        Win_data = '0;
        for (int k = 0; k < 9; k++) Win_data[DATA_W*k +: DATA_W] = win[k];
    end

`ifdef SOBEL_WIN_FRAME_CNT_EN
    always_ff @(posedge Clk) begin
        if (!Rst_n)                               Frame_cnt <= '0;
        else if (Win_valid && Win_ready && Win_last) Frame_cnt <= Frame_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomized bench for sobel_window_gen on a 5x4 image against a frame-level window model.
module tb_sobel_window_gen;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic              Rst_n, Valid_in, Win_ready;
    logic [DW-1:0]     Data_in;
    logic              Ready_from_IP, Win_valid, Win_last;
    logic [9*DW-1:0]   Win_data;
`ifdef SOBEL_WIN_FRAME_CNT_EN
    logic [15:0]       Frame_cnt;
    logic [15:0]       fc0;
`endif

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Valid_in(Valid_in), .Data_in(Data_in),
        .Ready_from_IP(Ready_from_IP), .Win_valid(Win_valid), .Win_data(Win_data),
        .Win_ready(Win_ready), .Win_last(Win_last)
`ifdef SOBEL_WIN_FRAME_CNT_EN
        , .Frame_cnt(Frame_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [9*DW-1:0] data;
        logic            last;
    } win_t;

    win_t          exp_q[$];
    win_t          mon_e;
    logic [DW-1:0] img [H][W];
    int            rdy_mode   = 0;
    int            stall_left = 0;

    // Win_ready driver: 0 always ready, 1 random, 2 hold off first pending window for stall_left cycles
    initial begin
        Win_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            case (rdy_mode)
                0:       Win_ready = 1'b1;
                1:       Win_ready = 1'($urandom_range(0, 1));
                default: if (Win_valid && stall_left > 0) begin
                             Win_ready = 1'b0;
                             stall_left--;
                         end else Win_ready = 1'b1;
            endcase
        end
    end

    logic            stall_prev = 1'b0;
    logic [9*DW-1:0] stall_data;

    always @(negedge Clk) begin
        if (Rst_n) begin
            chk("ready_rule", Ready_from_IP, !Win_valid || Win_ready);
            if (stall_prev) begin
                chk("hold_valid", Win_valid, 1'b1);
                chk("hold_data", Win_data, stall_data);
            end
            if (Win_valid && Win_ready) begin
                if (exp_q.size() == 0) chk("extra_win", exp_q.size(), 1);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("win_data", Win_data, mon_e.data);
                    chk("win_last", Win_last, mon_e.last);
                end
            end
            stall_prev <= Win_valid && !Win_ready;
            stall_data <= Win_data;
        end else begin
            stall_prev <= 1'b0;
        end
    end

    task automatic build(input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (pat == 0) ? 8'(r*16 + c) : 8'($urandom);
    endtask

    // Every interior pixel (r,c) yields the window centred on (r-1,c-1); lim bounds raster index
    task automatic enqueue(input int lim);
        win_t e;
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                if (r*W + c < lim) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.data[DW*(3*i + j) +: DW] = img[r-2+i][c-2+j];
                    e.last = (r == H-1) && (c == W-1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic send_px(input logic [DW-1:0] d, input int gap, input bit produce);
        bit took = 1'b0;
        for (int t = 0; t < 1000 && !took; t++) begin
            Valid_in = ($urandom_range(0, 99) >= gap);
            Data_in  = d;
            @(negedge Clk);
            took = Valid_in && Ready_from_IP;
            @(posedge Clk);
            #2;
        end
        if (!took) chk("accept_timeout", took, 1'b1);
        else if (produce) chk("latency", Win_valid, 1'b1);
    endtask

    task automatic send_frame(input int gap, input int npix);
        for (int idx = 0; idx < npix; idx++)
            send_px(img[idx / W][idx % W], gap, (idx / W >= 2) && (idx % W >= 2));
        Valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (exp_q.size() != 0 || Win_valid); t++) @(posedge Clk);
        #2;
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        Rst_n = 1'b0; Valid_in = 1'b0; Data_in = '0;
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;
        @(negedge Clk);
        chk("rst_valid", Win_valid, 1'b0);
        chk("rst_last", Win_last, 1'b0);
        chk("rst_data", Win_data, '0);
        chk("rst_ready", Ready_from_IP, 1'b1);
        @(posedge Clk); #2;

        // continuous stream, r*16+c pattern
        rdy_mode = 0; build(0); enqueue(W*H); send_frame(0, W*H); drain();

        // kernel stalls the first window for 3 cycles
        rdy_mode = 2; stall_left = 3; build(0); enqueue(W*H); send_frame(0, W*H); drain();

        // input gaps plus random back-pressure, known and random pixels
        rdy_mode = 1; build(0); enqueue(W*H); send_frame(50, W*H); drain();
        for (int f = 0; f < 3; f++) begin
            build(1); enqueue(W*H); send_frame(50, W*H); drain();
        end

        // back-to-back frames, random frame first so leakage would show up in the second
        rdy_mode = 0;
`ifdef SOBEL_WIN_FRAME_CNT_EN
        fc0 = Frame_cnt;
`endif
        build(1); enqueue(W*H); send_frame(0, W*H);
        build(0); enqueue(W*H); send_frame(0, W*H);
        drain();
`ifdef SOBEL_WIN_FRAME_CNT_EN
        chk("frame_cnt", Frame_cnt, 16'(fc0 + 16'd2));
`endif

        // reset right after accepting (2,3): its window is dropped
        build(0); enqueue(2*W + 3); send_frame(0, 2*W + 4);
        Rst_n = 1'b0;
        @(posedge Clk); #2;
        Rst_n = 1'b1;
        chk("midrst_valid", Win_valid, 1'b0);
        chk("midrst_queue", exp_q.size(), 0);
        exp_q.delete();
        build(0); enqueue(W*H); send_frame(0, W*H); drain();

        rdy_mode = 1; build(1); enqueue(W*H); send_frame(30, W*H); drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1);
    end
endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Upstream neighbour of the Sobel kernel stage. Takes the raster pixel stream (8-bit greyscale, one pixel per beat, Valid/Ready handshake) from the DMA side.
- Buffers the two previous image lines and presents a full 3x3 neighbourhood per beat to the kernel.
- Emits windows only for interior pixels (valid region), with a last flag on the final window of each frame.

Parameters:
- IMG_WIDTH, 1280, pixels per line (>=3)
- IMG_HEIGHT, 720, lines per frame (>=3)
- DATA_W, 8, bits per pixel

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Rst_n  in  1  synchronous active-low reset
- Valid_in  in  1  upstream pixel valid
- Data_in  in  DATA_W  upstream pixel, raster order, row-major
- Ready_from_IP  out  1  block can accept a pixel this cycle
- Win_valid  out  1  window valid to kernel
- Win_data  out  9*DATA_W  3x3 window; slice k=3*row+col at [DATA_W*k +: DATA_W], row 0 = oldest line, col 0 = leftmost
- Win_ready  in  1  kernel accepts window
- Win_last  out  1  final window of frame, qualified by Win_valid

Behaviour:
- Reset (Rst_n=0 at a Clk edge): Win_valid=0, Win_last=0, Win_data=0, col=0, row=0, state=FILL. Ready_from_IP=1 from the first cycle after reset. Line-buffer contents are don't-care.
- Accept: pixel taken when Valid_in && Ready_from_IP.
- Ready_from_IP = !Win_valid || Win_ready. This is a one-deep output register; full throughput is one pixel per cycle with no bubbles.
- Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1, advance only on accept.
  - col wraps to 0 at IMG_WIDTH-1 and row increments.
  - At col=IMG_WIDTH-1 and row=IMG_HEIGHT-1, both wrap to 0: next frame, back to FILL.
- Line buffers: two of them, depth IMG_WIDTH, addressed by col, asynchronous read, synchronous write on accept.
  - lb1 holds row-1, lb0 holds row-2.
  - On accept: lb0[col] <= lb1[col]; lb1[col] <= Data_in.
- Window shift regs: 3 rows x 3 cols. On accept, each row shifts left.
  - New right column = {lb0[col], lb1[col], Data_in} for rows 0, 1, 2.
- FSM:
  - FILL: row<2. Accepts pixels, no windows. Go to STREAM on the accept of pixel (row 1, col IMG_WIDTH-1).
  - STREAM: row>=2. Return to FILL on the accept of the frame's last pixel.
- Window emission:
  - An accept at (r, c) with r>=2 and c>=2 sets Win_valid=1 on the next cycle (latency 1). The window is centred on (r-1, c-1).
  - Accepts with c<2 update the shift regs only.
  - Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Win_valid and Win_data hold stable while Win_valid && !Win_ready.
  - Win_valid clears after a handshake unless a new window-producing accept occurs in the same cycle.
- Win_last = 1 with the window produced by the accept at (IMG_HEIGHT-1, IMG_WIDTH-1).
- Boundaries:
  - Line wrap: the shift regs are not cleared. Columns c=0 and c=1 refill them before the next emission.
  - Valid_in gaps: no state change.
  - Simultaneous Win_ready handshake and new accept: the new window replaces the old one in the same edge.
- Reset mid-frame: pending window dropped, counters cleared. The next pixel is treated as (0,0).

Optional Feature:
- Macro: SOBEL_WIN_FRAME_CNT_EN.
- Defined: adds output port Frame_cnt [15:0], reset 0, incremented on each Win_valid && Win_ready && Win_last handshake, wraps at 0xFFFF.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package sobel_pkg:
  - DATA_W and default IMG_WIDTH/IMG_HEIGHT constants
  - window index constants (TL=0 ... BR=8)
  - FSM state typedef {FILL, STREAM}
- Sub-module sobel_line_buf: one line memory, parameters DEPTH and DATA_W, async read, sync write. Instantiated twice.

Test Plan (IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = r*16+c; 6 windows/frame):
- Continuous stream, Win_ready=1 -> 6 windows. First window appears 1 cycle after accepting (2,2) and equals {00,01,02,10,11,12,20,21,22}. Win_last only on the 6th window, whose BR slice = 0x34.
- Win_ready=0 for 3 cycles while window 1 is pending -> Ready_from_IP=0, Win_data stable. After release, no window is lost or duplicated.
- Random Valid_in gaps (50%) plus random Win_ready -> window sequence identical to the gap-free run.
- Two back-to-back frames -> 12 windows. Frame 2's first window matches frame 1's, showing no leakage of frame 1 rows. With SOBEL_WIN_FRAME_CNT_EN, Frame_cnt = 2.
- Rst_n=0 for 1 cycle after accepting (2,3) -> Win_valid=0 next cycle. The restarted full frame yields exactly 6 correct windows.
- Default 1280x720, constant pixel 0x01 -> 1278*718 windows, all slices 0x01, exactly one Win_last.
